qspi_stream_reader: RTL and testbench

//   Parametrised Quad-Output (6Bh) flash streamer. Issues command + address serially on IO0, runs

---
 rtl/qspi_pkg.sv | 20 ++
 rtl/qspi_word_fifo.sv | 50 +++++
 rtl/qspi_stream_reader.sv | 177 +++++++++++++++++
 tb/tb_qspi_stream_reader.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared types for the quad-output flash streamer.
// State encodings and counter widths used by the top.
package qspi_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DUMMY,
      S_DATA,
      S_STALL,
      S_DESEL
   } state_t;

   localparam logic [7:0] CMD_QUAD_OUT = 8'h6B;

   // Holds counts up to 32 address bits / 31 dummy cycles / CS-high time.
   localparam int CNT_W = 6;

endpackage

// File: rtl/qspi_word_fifo.sv
// Synchronous word FIFO with flush; head is registered
// storage, zero when empty.
module qspi_word_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) &&
                    (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A pop frees the slot being written, so push into full is fine then.
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem[rptr[AW-1:0]];

   // Pointer update; flush empties the queue in one clock.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   // Storage write.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/qspi_stream_reader.sv
// Quad-output (6Bh) flash streamer: serial cmd/addr,
// dummy cycles, continuous nibble reads into a word FIFO.
module qspi_stream_reader
   import qspi_pkg::*;
#(
   parameter int         WORD_BITS    = 20,
   parameter int         ADDR_BITS    = 24,
   parameter int         DUMMY_CYCLES = 8,
   parameter int         FIFO_DEPTH   = 4,
   parameter logic [7:0] CMD_BYTE     = CMD_QUAD_OUT,
   parameter int         CS_HIGH_CYC  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_BITS-1:0] start_addr,
   input  logic                 stop,
   output logic                 spi_cs_n,
   output logic                 spi_clk,
   input  logic [3:0]           spi_io_in,
   output logic [3:0]           spi_io_out,
   output logic [3:0]           spi_io_oe,
   output logic [WORD_BITS-1:0] rd_data,
   output logic                 rd_valid,
   input  logic                 rd_ready,
   output logic                 busy
);

   localparam int NIBS = WORD_BITS / 4;
   localparam int NW   = (NIBS > 1) ? $clog2(NIBS) : 1;
   localparam int SW   = 8 + ADDR_BITS;
   localparam int PW   = (WORD_BITS > 4) ? WORD_BITS - 4 : 1;

   state_t             state;
   logic               phase;
   logic [CNT_W-1:0]   cnt;
   logic [NW-1:0]      nib;
   logic [SW-1:0]      sreg;
   logic [PW-1:0]      pack;
   logic [3:0]         in_q;
   logic [WORD_BITS-1:0] word;
   logic               stop_hit;
   logic               push;
   logic               pop;
   logic               full;
   logic               empty;

   if (WORD_BITS == 4) begin : g_one
      assign word = in_q;
   end else begin : g_many
      assign word = {pack, in_q};
   end

   assign stop_hit = stop && (state != S_IDLE);
   assign push     = !stop_hit && (state == S_DATA) &&
                     phase && (nib == NW'(NIBS - 1));
   assign pop      = rd_ready && !empty;
   assign rd_valid = !empty;
   assign busy     = (state != S_IDLE);

   qspi_word_fifo #(
      .WIDTH (WORD_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (stop_hit),
      .push      (push),
      .push_data (word),
      .pop       (pop),
      .head      (rd_data),
      .full      (full),
      .empty     (empty)
   );

   // Sequencer: SCK phase, serial out, nibble capture and packing.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         spi_cs_n   <= 1'b1;
         spi_clk    <= 1'b0;
         spi_io_out <= 4'h0;
         spi_io_oe  <= 4'h0;
         phase      <= 1'b0;
         cnt        <= '0;
         nib        <= '0;
         sreg       <= '0;
         pack       <= '0;
         in_q       <= 4'h0;
      end else if (stop_hit) begin
         state      <= S_DESEL;
         spi_cs_n   <= 1'b1;
         spi_clk    <= 1'b0;
         spi_io_out <= 4'h0;
         spi_io_oe  <= 4'h0;
         phase      <= 1'b0;
         cnt        <= '0;
         nib        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_CMD;
                  spi_cs_n   <= 1'b0;
                  phase      <= 1'b0;
                  cnt        <= '0;
                  spi_io_out <= {3'b000, CMD_BYTE[7]};
                  spi_io_oe  <= 4'b0001;
                  sreg       <= {CMD_BYTE[6:0], start_addr, 1'b0};
               end
            end
            S_CMD, S_ADDR, S_DUMMY: begin
               if (!phase) begin
                  phase   <= 1'b1;
                  spi_clk <= 1'b1;
                  in_q    <= spi_io_in;
               end else begin
                  phase      <= 1'b0;
                  spi_clk    <= 1'b0;
                  cnt        <= cnt + 1'b1;
                  spi_io_out <= {3'b000, sreg[SW-1]};
                  sreg       <= {sreg[SW-2:0], 1'b0};
                  if (state == S_CMD && cnt == CNT_W'(7)) begin
                     state <= S_ADDR;
                     cnt   <= '0;
                  end
                  if (state == S_ADDR &&
                      cnt == CNT_W'(ADDR_BITS - 1)) begin
                     cnt        <= '0;
                     nib        <= '0;
                     spi_io_out <= 4'h0;
                     spi_io_oe  <= 4'h0;
                     state      <= (DUMMY_CYCLES == 0) ?
                                   S_DATA : S_DUMMY;
                  end
                  if (state == S_DUMMY &&
                      cnt == CNT_W'(DUMMY_CYCLES - 1)) begin
                     cnt   <= '0;
                     nib   <= '0;
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (!phase) begin
                  // Only stall between words, never mid-word.
                  if (nib == '0 && full && !pop) begin
                     state <= S_STALL;
                  end else begin
                     phase   <= 1'b1;
                     spi_clk <= 1'b1;
                     in_q    <= spi_io_in;
                  end
               end else begin
                  phase   <= 1'b0;
                  spi_clk <= 1'b0;
                  pack    <= word[PW-1:0];
                  nib     <= (nib == NW'(NIBS - 1)) ?
                             '0 : nib + 1'b1;
               end
            end
            S_STALL: begin
               if (pop) state <= S_DATA;
            end
            S_DESEL: begin
               if (cnt == CNT_W'(CS_HIGH_CYC - 1)) begin
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qspi_stream_reader.sv
// Scoreboard bench for qspi_stream_reader with a
// behavioural flash model (default and 8/0/32 configs).
module tb_qspi_stream_reader;

   localparam int A    = 24;
   localparam int W    = 20;
   localparam int PRE  = 8 + A + 8;
   localparam int PRE8 = 8 + 32;
   localparam logic [39:0] PAT = 40'hABCDE12345;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic stop = 1'b0;
   logic rd_ready = 1'b1;
   logic [23:0] start_addr = '0;
   logic cs_n, sck, rd_valid, busy;
   logic [3:0] io_in = 4'h0;
   logic [3:0] io_out, io_oe;
   logic [W-1:0] rd_data;

   logic start8 = 1'b0;
   logic stop8 = 1'b0;
   logic ready8 = 1'b1;
   logic [31:0] start_addr8 = '0;
   logic cs8, sck8, valid8, busy8;
   logic [3:0] io_in8 = 4'h0;
   logic [3:0] io_out8, oe8;
   logic [7:0] data8;

   int total = 0;
   int bad = 0;
   int got = 0;
   int got8 = 0;
   logic [W-1:0] sb[$];
   logic [7:0] sb8[$];
   logic [23:0] exp_addr = '0;
   logic [31:0] exp_addr8 = '0;
   bit fixed = 1'b0;

   int rises = 0;
   int falls = 0;
   bit psck = 1'b0;
   bit oe_bad = 1'b0;
   logic [39:0] ca = '0;
   int rises8 = 0;
   int falls8 = 0;
   bit psck8 = 1'b0;
   bit oe_bad8 = 1'b0;
   logic [39:0] ca8 = '0;

   always #5 clk = ~clk;

   qspi_stream_reader dut (
      .clk(clk), .rst(rst), .start(start),
      .start_addr(start_addr), .stop(stop),
      .spi_cs_n(cs_n), .spi_clk(sck),
      .spi_io_in(io_in), .spi_io_out(io_out),
      .spi_io_oe(io_oe), .rd_data(rd_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready),
      .busy(busy)
   );

   qspi_stream_reader #(
      .WORD_BITS(8), .ADDR_BITS(32), .DUMMY_CYCLES(0)
   ) dut8 (
      .clk(clk), .rst(rst), .start(start8),
      .start_addr(start_addr8), .stop(stop8),
      .spi_cs_n(cs8), .spi_clk(sck8),
      .spi_io_in(io_in8), .spi_io_out(io_out8),
      .spi_io_oe(oe8), .rd_data(data8),
      .rd_valid(valid8), .rd_ready(ready8),
      .busy(busy8)
   );

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   task automatic fail(input string nm);
      total++;
      bad++;
      $display("FAIL %s: got timeout want event", nm);
   endtask

   // Flash content: one hashed byte per address.
   function automatic logic [7:0] fbyte(input logic [31:0] a);
      logic [31:0] h;
      h = a * 32'h9E3779B1;
      return h[31:24] ^ a[7:0];
   endfunction

   // Nibble d of a quad read starting at a: high half first.
   function automatic logic [3:0] fnib(input logic [31:0] a,
                                       input int d,
                                       input bit fx);
      logic [7:0] b;
      int j;
      if (fx) begin
         j = d % 10;
         return PAT[39-4*j -: 4];
      end
      b = fbyte(a + 32'(d / 2));
      return (d % 2 == 0) ? b[7:4] : b[3:0];
   endfunction

   function automatic logic [W-1:0] word20(input logic [31:0] a,
                                           input int k,
                                           input bit fx);
      logic [W-1:0] w = '0;
      for (int i = 0; i < W / 4; i++)
         w = {w[W-5:0], fnib(a, k * (W / 4) + i, fx)};
      return w;
   endfunction

   // Flash models and output monitors, sampled 2ns after each edge.
   always @(posedge clk) begin
      #2;
      if (cs_n) begin
         rises = 0;
         falls = 0;
         oe_bad = 1'b0;
      end else begin
         if (sck && !psck) begin
            if (rises < 8 + A) begin
               ca = {ca[38:0], io_out[0]};
               if (io_oe !== 4'b0001) oe_bad = 1'b1;
            end else if (io_oe !== 4'b0000) oe_bad = 1'b1;
            rises++;
            if (rises == 8 + A) begin
               chk("opcode", 64'(ca[31:24]), 64'h6B);
               chk("addr", 64'(ca[23:0]), 64'(exp_addr));
            end
            if (rises == PRE + 1)
               chk("oe", 64'(oe_bad), 64'(0));
         end
         if (!sck && psck) falls++;
      end
      psck = sck;
      io_in = (!cs_n && falls >= PRE) ?
              fnib({8'h0, ca[23:0]}, falls - PRE, fixed) : 4'h0;

      if (cs8) begin
         rises8 = 0;
         falls8 = 0;
         oe_bad8 = 1'b0;
      end else begin
         if (sck8 && !psck8) begin
            if (rises8 < PRE8) begin
               ca8 = {ca8[38:0], io_out8[0]};
               if (oe8 !== 4'b0001) oe_bad8 = 1'b1;
            end else if (oe8 !== 4'b0000) oe_bad8 = 1'b1;
            rises8++;
            if (rises8 == PRE8) begin
               chk("opcode8", 64'(ca8[39:32]), 64'h6B);
               chk("addr8", 64'(ca8[31:0]), 64'(exp_addr8));
            end
            if (rises8 == PRE8 + 1)
               chk("oe8", 64'(oe_bad8), 64'(0));
         end
         if (!sck8 && psck8) falls8++;
      end
      psck8 = sck8;
      io_in8 = (!cs8 && falls8 >= PRE8) ?
               fnib(ca8[31:0], falls8 - PRE8, 1'b0) : 4'h0;

      if (rd_valid && rd_ready && !stop && !rst) begin
         if (sb.size() == 0) fail("unexpected_word");
         else begin
            chk("rd_data", 64'(rd_data), 64'(sb.pop_front()));
            got++;
         end
      end
      if (valid8 && ready8 && !stop8 && !rst) begin
         if (sb8.size() == 0) fail("unexpected_byte");
         else begin
            chk("rd_data8", 64'(data8), 64'(sb8.pop_front()));
            got8++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_stream(input logic [23:0] a,
                               input bit fx,
                               input bit with_stop);
      fixed = fx;
      exp_addr = a;
      sb.delete();
      for (int k = 0; k < 80; k++)
         sb.push_back(word20({8'h0, a}, k, fx));
      start_addr = a;
      start = 1'b1;
      stop = with_stop;
      tick();
      start = 1'b0;
      stop = 1'b0;
   endtask

   task automatic wait_words(input int n);
      int c = 0;
      while (got < n && c < 2000) begin
         tick();
         c++;
      end
      if (got < n) fail("wait_words");
   endtask

   task automatic wait_idle();
      int c = 0;
      while (busy && c < 20) begin
         tick();
         c++;
      end
      if (busy) fail("wait_idle");
   endtask

   task automatic end_stream();
      stop = 1'b1;
      sb.delete();
      tick();
      stop = 1'b0;
      wait_idle();
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_cs"}, 64'(cs_n), 64'(1));
      chk({nm, "_sck"}, 64'(sck), 64'(0));
      chk({nm, "_io"}, 64'(io_out), 64'(0));
      chk({nm, "_oe"}, 64'(io_oe), 64'(0));
      chk({nm, "_valid"}, 64'(rd_valid), 64'(0));
      chk({nm, "_data"}, 64'(rd_data), 64'(0));
      chk({nm, "_busy"}, 64'(busy), 64'(0));
   endtask

   initial begin
      int n;
      int g0;
      logic [23:0] a;

      repeat (3) tick();
      chk_reset("reset");
      chk("reset_cs8", 64'(cs8), 64'(1));
      rst = 1'b0;
      tick();

      // Fixed pattern at 012345: latency and first words.
      begin_stream(24'h012345, 1'b1, 1'b0);
      n = 1;
      while (!rd_valid && n < 200) begin
         tick();
         n++;
      end
      chk("latency", 64'(n), 64'(91));
      chk("first_word", 64'(rd_data), 64'hABCDE);
      wait_words(6);
      end_stream();

      // Back-pressure: 200 clk with rd_ready low.
      g0 = got;
      a = 24'($urandom);
      rd_ready = 1'b0;
      begin_stream(a, 1'b0, 1'b0);
      repeat (200) tick();
      chk("stall_nibbles", 64'(rises - PRE), 64'(20));
      chk("stall_sck", 64'(sck), 64'(0));
      chk("stall_cs", 64'(cs_n), 64'(0));
      chk("stall_valid", 64'(rd_valid), 64'(1));
      chk("stall_got", 64'(got - g0), 64'(0));
      repeat (300) begin
         rd_ready = 1'($urandom_range(0, 1));
         tick();
      end
      rd_ready = 1'b1;
      chk("release_got", 64'(got - g0 >= 8), 64'(1));
      end_stream();

      // Stop mid-word, then restart with start+stop together.
      begin_stream(24'($urandom), 1'b0, 1'b0);
      n = 0;
      while (!(rises > PRE + 5 && (rises - PRE) % 5 == 2)
             && n < 500) begin
         tick();
         n++;
      end
      if (n >= 500) fail("midword_wait");
      stop = 1'b1;
      sb.delete();
      tick();
      stop = 1'b0;
      chk("stop_cs", 64'(cs_n), 64'(1));
      chk("stop_sck", 64'(sck), 64'(0));
      chk("stop_valid", 64'(rd_valid), 64'(0));
      chk("stop_busy0", 64'(busy), 64'(1));
      tick();
      chk("stop_busy1", 64'(busy), 64'(1));
      chk("stop_cs1", 64'(cs_n), 64'(1));
      tick();
      chk("stop_busy2", 64'(busy), 64'(0));
      begin_stream(24'($urandom), 1'b0, 1'b1);
      chk("restart_cs", 64'(cs_n), 64'(0));
      wait_words(got + 4);
      end_stream();

      // Reset during dummy cycles.
      begin_stream(24'($urandom), 1'b0, 1'b0);
      n = 0;
      while (!(rises > 8 + A + 2) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) fail("dummy_wait");
      rst = 1'b1;
      sb.delete();
      tick();
      chk_reset("rst_dummy");
      rst = 1'b0;
      tick();

      // Start ignored while busy, then reset in stall.
      a = 24'($urandom);
      begin_stream(a, 1'b0, 1'b0);
      wait_words(got + 3);
      start_addr = ~a;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_start_cs", 64'(cs_n), 64'(0));
      wait_words(got + 3);
      rd_ready = 1'b0;
      repeat (120) tick();
      chk("stall2_sck", 64'(sck), 64'(0));
      chk("stall2_valid", 64'(rd_valid), 64'(1));
      rst = 1'b1;
      sb.delete();
      tick();
      chk_reset("rst_stall");
      rst = 1'b0;
      rd_ready = 1'b1;
      tick();

      // Byte words, no dummy, 32-bit address.
      exp_addr8 = $urandom;
      sb8.delete();
      for (int k = 0; k < 64; k++)
         sb8.push_back({fnib(exp_addr8, 2 * k, 1'b0),
                        fnib(exp_addr8, 2 * k + 1, 1'b0)});
      start_addr8 = exp_addr8;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      n = 0;
      while (got8 < 12 && n < 1000) begin
         tick();
         n++;
      end
      if (got8 < 12) fail("wait_bytes");
      stop8 = 1'b1;
      sb8.delete();
      tick();
      stop8 = 1'b0;
      repeat (4) tick();
      chk("busy8_end", 64'(busy8), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
